// File: rtl/fec_secded_decoder.sv
// Receive-side SECDED decoder: two extended Hamming(8,4) codewords per 16-bit word, decoded low then high.
// Optional saturating error statistics are built only when FEC_ERR_COUNT_EN is defined.
module fec_secded_decoder #(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               req,
    input  logic [15:0]        data_in,
    input  logic               clr_count,
    output logic               ack,
    output logic [7:0]         data_out,
    output logic               err_corrected,
    output logic               err_uncorrectable,
    output logic [COUNT_W-1:0] corr_count,
    output logic [COUNT_W-1:0] uncorr_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DEC_LO = 2'd1,
        DEC_HI = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t      state_r;
    logic [15:0] word_r;
    logic [3:0]  lo_nib_r;
    logic        lo_single_r;
    logic        lo_double_r;
    logic        ack_r;
    logic [7:0]  data_out_r;
    logic        err_corr_r;
    logic        err_uncorr_r;

    logic [5:0]  lo_dec_s;
    logic [5:0]  hi_dec_s;
    logic        word_single_s;
    logic        word_double_s;
    logic        complete_s;

    // Syndrome {s4,s2,s1}; a nonzero value names the bit position in error.
    function automatic logic [2:0] secded_syndrome(input logic [7:0] c);
        return {c[4] ^ c[5] ^ c[6] ^ c[7],
                c[2] ^ c[3] ^ c[6] ^ c[7],
                c[1] ^ c[3] ^ c[5] ^ c[7]};
    endfunction

    // Returns {double, single, d3, d2, d1, d0}; odd overall parity means one flipped bit at the syndrome position.
    function automatic logic [5:0] secded_decode(input logic [7:0] c);
        logic [2:0] syn;
        logic [7:0] fixed;
        logic       single;
        logic       dbl;
        syn    = secded_syndrome(c);
        fixed  = c;
        single = 1'b0;
        dbl    = 1'b0;
        if (^c) begin
            fixed  = c ^ (8'b0000_0001 << syn);
            single = 1'b1;
        end else if (syn != 3'd0) begin
            dbl = 1'b1;
        end else begin
            fixed = c;
        end
        return {dbl, single, fixed[7], fixed[6], fixed[5], fixed[3]};
    endfunction

    // Decode both halves of the captured word and merge the per-word error class.
    always_comb begin
        lo_dec_s      = secded_decode(word_r[7:0]);
        hi_dec_s      = secded_decode(word_r[15:8]);
        word_double_s = lo_double_r | hi_dec_s[5];
        word_single_s = ~word_double_s & (lo_single_r | hi_dec_s[4]);
        complete_s    = en & (state_r == DEC_HI);
    end

    // Handshake FSM with registered outputs; en=0 freezes everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            word_r       <= 16'h0000;
            lo_nib_r     <= 4'h0;
            lo_single_r  <= 1'b0;
            lo_double_r  <= 1'b0;
            ack_r        <= 1'b0;
            data_out_r   <= 8'h00;
            err_corr_r   <= 1'b0;
            err_uncorr_r <= 1'b0;
        end else if (en) begin
            case (state_r)
                IDLE: begin
                    if (req) begin
                        word_r  <= data_in;
                        state_r <= DEC_LO;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                DEC_LO: begin
                    lo_nib_r    <= lo_dec_s[3:0];
                    lo_single_r <= lo_dec_s[4];
                    lo_double_r <= lo_dec_s[5];
                    state_r     <= DEC_HI;
                end
                DEC_HI: begin
                    data_out_r   <= {hi_dec_s[3:0], lo_nib_r};
                    err_corr_r   <= word_single_s;
                    err_uncorr_r <= word_double_s;
                    ack_r        <= 1'b1;
                    state_r      <= DONE;
                end
                DONE: begin
                    if (!req) begin
                        ack_r   <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        ack_r   <= 1'b1;
                        state_r <= DONE;
                    end
                end
                default: begin
                    ack_r   <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign ack               = ack_r;
    assign data_out          = data_out_r;
    assign err_corrected     = err_corr_r;
    assign err_uncorrectable = err_uncorr_r;

`ifdef FEC_ERR_COUNT_EN
    logic [COUNT_W-1:0] corr_cnt_r;
    logic [COUNT_W-1:0] uncorr_cnt_r;

    // Saturating statistics; a clear on the completion edge beats the increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corr_cnt_r   <= {COUNT_W{1'b0}};
            uncorr_cnt_r <= {COUNT_W{1'b0}};
        end else if (en && clr_count) begin
            corr_cnt_r   <= {COUNT_W{1'b0}};
            uncorr_cnt_r <= {COUNT_W{1'b0}};
        end else if (complete_s) begin
            if (word_double_s) begin
                if (uncorr_cnt_r != {COUNT_W{1'b1}}) begin
                    uncorr_cnt_r <= uncorr_cnt_r + {{(COUNT_W-1){1'b0}}, 1'b1};
                end else begin
                    uncorr_cnt_r <= uncorr_cnt_r;
                end
            end else if (word_single_s) begin
                if (corr_cnt_r != {COUNT_W{1'b1}}) begin
                    corr_cnt_r <= corr_cnt_r + {{(COUNT_W-1){1'b0}}, 1'b1};
                end else begin
                    corr_cnt_r <= corr_cnt_r;
                end
            end else begin
                corr_cnt_r <= corr_cnt_r;
            end
        end else begin
            corr_cnt_r   <= corr_cnt_r;
            uncorr_cnt_r <= uncorr_cnt_r;
        end
    end

    assign corr_count   = corr_cnt_r;
    assign uncorr_count = uncorr_cnt_r;
`else
    logic unused_count_s;
    assign unused_count_s = clr_count ^ complete_s;
    assign corr_count     = {COUNT_W{1'b0}};
    assign uncorr_count   = {COUNT_W{1'b0}};
`endif

endmodule
